// File: rtl/id_inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: default sizes and exception tag layout.
package id_inst_queue_pkg;
    localparam int unsigned IQ_DEPTH   = 4;
    localparam int unsigned IQ_TAG_W   = 7;
    localparam int unsigned XLEN       = 32;

    // Tag layout {ex, RI, ds, Ov, ...} from the MSB down
    localparam int unsigned TAG_EX_BIT = 6;
    localparam int unsigned TAG_RI_BIT = 5;
    localparam int unsigned TAG_DS_BIT = 4;
    localparam int unsigned TAG_OV_BIT = 3;
endpackage

// File: rtl/id_inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
interface id_inst_queue_if
    import id_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned TAG_W = IQ_TAG_W
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_inst;
    logic [TAG_W-1:0] in_tag;
    logic [XLEN-1:0]  in_badvaddr;
    logic             out_valid;
    logic             out_ready;
    logic             redirect;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_pc_4;
    logic [XLEN-1:0]  out_inst;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_badvaddr;
    logic             out_is_ds;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_tag, in_badvaddr, out_ready, redirect,
        input  in_ready, out_valid, out_pc, out_pc_4, out_inst, out_tag, out_badvaddr,
               out_is_ds, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_tag, in_badvaddr, out_ready, redirect,
        output in_ready, out_valid, out_pc, out_pc_4, out_inst, out_tag, out_badvaddr,
               out_is_ds, count
    );
endinterface

// File: rtl/id_iq_mem.sv
// Entry storage for the instruction queue: one write port, one asynchronous read port, no data reset.
module id_iq_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata_c
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];
endmodule

// File: rtl/id_inst_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO with delay-slot marking, redirect trim and full flush.
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned TAG_W = IQ_TAG_W
) (
    input  logic          clk,
    input  logic          resetn,
    id_inst_queue_if.slave q
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned EW    = XLEN + XLEN + TAG_W + XLEN + 1;

    logic [PW-1:0]    r_rd, r_wr;
    logic             r_ds_pending;
    logic             r_head_ds;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [PW-1:0]    w_rd_n, w_wr_n;
    logic             w_pending_n, w_head_ds_n;
    logic             w_we, w_wds;
    logic             w_push, w_pop, w_redir;
    logic [CNT_W-1:0] w_count, w_count_n;
    logic [EW-1:0]    w_wdata, w_rdata;
    logic [XLEN-1:0]  w_h_pc, w_h_inst, w_h_bad;
    logic [TAG_W-1:0] w_h_tag, w_ds_mask;
    logic             w_h_ds, w_is_ds;

    assign w_count = CNT_W'(r_wr - r_rd);
    assign w_push  = q.in_valid & r_in_ready;
    assign w_pop   = r_out_valid & q.out_ready;
    assign w_redir = q.redirect & w_pop & ~r_ds_pending;

    // Pointer/flag update: flush beats redirect, redirect trims to at most one delay-slot entry
    always_comb begin
        w_rd_n      = r_rd;
        w_wr_n      = r_wr;
        w_pending_n = r_ds_pending;
        w_head_ds_n = r_head_ds;
        w_we        = 1'b0;
        w_wds       = r_ds_pending;
        if (q.flush) begin
            w_rd_n      = r_wr;
            w_pending_n = 1'b0;
            w_head_ds_n = 1'b0;
        end else if (w_redir) begin
            w_rd_n      = r_rd + PW'(1);
            w_head_ds_n = 1'b0;
            if (w_count > CNT_W'(1)) begin
                w_wr_n      = r_rd + PW'(2);
                w_head_ds_n = 1'b1;
            end else if (w_push) begin
                w_we   = 1'b1;
                w_wds  = 1'b1;
                w_wr_n = r_wr + PW'(1);
            end else begin
                w_pending_n = 1'b1;
            end
        end else begin
            if (w_push) begin
                w_we        = 1'b1;
                w_wr_n      = r_wr + PW'(1);
                w_pending_n = 1'b0;
            end
            if (w_pop) begin
                w_rd_n      = r_rd + PW'(1);
                w_head_ds_n = 1'b0;
            end
        end
    end

    assign w_count_n = CNT_W'(w_wr_n - w_rd_n);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_ds_pending <= 1'b0;
            r_head_ds    <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_rd         <= w_rd_n;
            r_wr         <= w_wr_n;
            r_ds_pending <= w_pending_n;
            r_head_ds    <= w_head_ds_n;
            r_in_ready   <= (w_count_n < CNT_W'(DEPTH));
            r_out_valid  <= (w_count_n != '0);
        end
    end

    assign w_wdata = {q.in_pc, q.in_inst, q.in_tag, q.in_badvaddr, w_wds};

    id_iq_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (r_wr[AW-1:0]),
        .i_wdata   (w_wdata),
        .i_raddr   (r_rd[AW-1:0]),
        .o_rdata_c (w_rdata)
    );

    assign w_h_pc   = w_rdata[EW-1 -: XLEN];
    assign w_h_inst = w_rdata[EW-XLEN-1 -: XLEN];
    assign w_h_tag  = w_rdata[XLEN+TAG_W : XLEN+1];
    assign w_h_bad  = w_rdata[XLEN:1];
    assign w_h_ds   = w_rdata[0];
    assign w_is_ds  = w_h_ds | r_head_ds;

    // Delay-slot flag is folded into the tag so decode has a single source
    always_comb begin
        w_ds_mask = '0;
        if (w_is_ds) begin
            w_ds_mask[TAG_DS_BIT] = 1'b1;
        end
    end

    assign q.in_ready     = r_in_ready;
    assign q.out_valid    = r_out_valid;
    assign q.count        = w_count;
    assign q.out_pc       = r_out_valid ? w_h_pc : '0;
    assign q.out_pc_4     = r_out_valid ? (w_h_pc + XLEN'(4)) : '0;
    assign q.out_inst     = r_out_valid ? w_h_inst : '0;
    assign q.out_tag      = r_out_valid ? (w_h_tag | w_ds_mask) : '0;
    assign q.out_badvaddr = r_out_valid ? w_h_bad : '0;
    assign q.out_is_ds    = r_out_valid & w_is_ds;
endmodule
